// File: rtl/dcache_wb_buffer_pkg.sv
// ---------------------------------------------------------------------------
// dcache_wb_buffer_pkg
//
// Definitions shared between the data cache, its write buffer and the AXI
// read bridge: cache write request type codes, the AXI burst/size encodings
// used by the cache-side masters, and the write buffer state encoding.
// ---------------------------------------------------------------------------
package dcache_wb_buffer_pkg;

    // Cache write request type codes (wr_type)
    localparam logic [2:0] WR_TYPE_BYTE = 3'b000;
    localparam logic [2:0] WR_TYPE_HALF = 3'b001;
    localparam logic [2:0] WR_TYPE_WORD = 3'b010;
    localparam logic [2:0] WR_TYPE_LINE = 3'b100;

    // AXI burst type and transfer size encodings
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_1     = 3'b000;
    localparam logic [2:0] AXI_SIZE_2     = 3'b001;
    localparam logic [2:0] AXI_SIZE_4     = 3'b010;

    // Write buffer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_RESP = 2'd2
    } wb_state_e;

endpackage

// File: rtl/dcache_wb_buffer.sv
// ---------------------------------------------------------------------------
// dcache_wb_buffer
//
// Single-entry write buffer between the data cache write port and AXI.
// One request (a 4-word dirty line or an uncached byte/half/word store) is
// captured in IDLE, which frees the cache at once; the entry is then issued
// on AW and W concurrently and retired on the B handshake.
//
// Ports:
//   aclk, aresetn         clock, asynchronous active-low reset
//   wr_req/wr_type/wr_addr/wr_wstrb/wr_data   cache write request
//   wr_rdy                buffer can accept a request this cycle
//   rd_chk_addr/rd_hazard refill address check against the buffered line
//   wb_empty              no write outstanding
//   aw*/w*/b*             AXI write address, write data and response channels
// ---------------------------------------------------------------------------
module dcache_wb_buffer
    import dcache_wb_buffer_pkg::*;
#(
    parameter logic [3:0] WR_ID      = 4'd1,
    parameter int         LINE_BEATS = 4
) (
    input  logic         aclk,
    input  logic         aresetn,

    input  logic         wr_req,
    input  logic [2:0]   wr_type,
    input  logic [31:0]  wr_addr,
    input  logic [3:0]   wr_wstrb,
    input  logic [127:0] wr_data,
    output logic         wr_rdy,

    input  logic [31:0]  rd_chk_addr,
    output logic         rd_hazard,
    output logic         wb_empty,

    output logic [3:0]   awid,
    output logic [31:0]  awaddr,
    output logic [7:0]   awlen,
    output logic [2:0]   awsize,
    output logic [1:0]   awburst,
    output logic [1:0]   awlock,
    output logic [3:0]   awcache,
    output logic [2:0]   awprot,
    output logic         awvalid,
    input  logic         awready,

    output logic [3:0]   wid,
    output logic [31:0]  wdata,
    output logic [3:0]   wstrb,
    output logic         wlast,
    output logic         wvalid,
    input  logic         wready,

    input  logic [3:0]   bid,
    input  logic [1:0]   bresp,
    input  logic         bvalid,
    output logic         bready
);

    localparam int BEAT_W = $clog2(LINE_BEATS);

    wb_state_e          state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [127:0]       data_q, data_d;
    logic [3:0]         wstrb_q, wstrb_d;
    logic [2:0]         type_q, type_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic               aw_done_q, aw_done_d;
    logic               w_done_q, w_done_d;

    logic               isLine;
    logic               unused_inputs;

    // The B response id/status and the in-line offset of the refill address
    // carry no information this buffer acts on.
    assign unused_inputs = ^{bid, bresp, rd_chk_addr[3:0]};

    // State register and captured entry
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            wstrb_q   <= '0;
            type_q    <= '0;
            beat_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            wstrb_q   <= wstrb_d;
            type_q    <= type_d;
            beat_q    <= beat_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // AXI address/data channel decode from the captured entry. Valids are
    // pure state decodes, so they are stable until their handshake; wlast is
    // qualified by wvalid so it stays low whenever no beat is offered.
    assign isLine  = (type_q == WR_TYPE_LINE);
    assign awid    = WR_ID;
    assign wid     = WR_ID;
    assign awaddr  = addr_q;
    assign awlen   = isLine ? 8'(LINE_BEATS - 1) : 8'd0;
    assign awburst = AXI_BURST_INCR;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;
    assign awvalid = (state_q == ST_SEND) && !aw_done_q;
    assign wvalid  = (state_q == ST_SEND) && !w_done_q;
    assign wdata   = data_q[32*beat_q +: 32];
    assign wstrb   = isLine ? 4'hF : wstrb_q;
    assign wlast   = wvalid && (8'(beat_q) == awlen);

    always_comb begin
        awsize = AXI_SIZE_1;
        case (type_q)
            WR_TYPE_LINE, WR_TYPE_WORD: awsize = AXI_SIZE_4;
            WR_TYPE_HALF:               awsize = AXI_SIZE_2;
            default:                    awsize = AXI_SIZE_1;
        endcase
    end

    // Refill hazard covers any entry still owned by the buffer, uncached
    // stores included, and falls the moment the buffer is back in IDLE.
    assign rd_hazard = (state_q != ST_IDLE) && (rd_chk_addr[31:4] == addr_q[31:4]);
    assign wb_empty  = (state_q == ST_IDLE);

    // Next-state logic. AW and W progress independently in SEND; a handshake
    // in the current cycle counts as done when deciding to leave SEND.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        wstrb_d   = wstrb_q;
        type_d    = type_q;
        beat_d    = beat_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        wr_rdy    = 1'b0;
        bready    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                wr_rdy = 1'b1;
                if (wr_req) begin
                    addr_d  = (wr_type == WR_TYPE_LINE) ? {wr_addr[31:4], 4'h0} : wr_addr;
                    data_d  = wr_data;
                    wstrb_d = wr_wstrb;
                    type_d  = wr_type;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (awvalid && awready) begin
                    aw_done_d = 1'b1;
                end
                if (wvalid && wready) begin
                    if (wlast) begin
                        w_done_d = 1'b1;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
                if (aw_done_d && w_done_d) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    state_d   = ST_IDLE;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    beat_d    = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/dcache_wb_buffer.md
Name: dcache_wb_buffer

Overview:
Single-entry write buffer that sits directly downstream of the data cache's write interface. It accepts one dirty-line eviction (4×32-bit) or one uncached store per request and issues it on the AXI AW/W/B channels. It frees the cache immediately after capture. A combinational hazard output lets the read arbiter stall a cache refill whose line is still in flight in the buffer.

Parameters:
WR_ID, 4'd1, constant driven on awid and wid
LINE_BEATS, 4, beats per cache line; only 4 is supported

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
wr_req  in  1  cache write request
wr_type  in  3  request type: 3'b000 byte, 3'b001 half, 3'b010 word, 3'b100 line
wr_addr  in  32  write address
wr_wstrb  in  4  byte strobes; used only for non-line types
wr_data  in  128  line data; word i is at [32i+31:32i]; non-line types use [31:0]
wr_rdy  out  1  buffer can accept a request this cycle
rd_chk_addr  in  32  address of the cache's pending refill
rd_hazard  out  1  rd_chk_addr line matches the buffered, not-yet-retired line
wb_empty  out  1  no write outstanding
awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid  out  4/32/8/3/2/2/4/3/1  AXI write address
awready  in  1
wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1  AXI write data
wready  in  1
bid  in  4  ignored
bresp  in  2  ignored
bvalid  in  1
bready  out  1

Behaviour:
- Clock and reset: one clock, aclk. Reset aresetn is asynchronous and active-low.
- Reset:
  - State goes to IDLE.
  - awvalid, wvalid, wlast and bready go to 0.
  - wr_rdy = 1 and wb_empty = 1.
  - rd_hazard = 0.
  - The beat counter and the aw_done and w_done flags clear to 0.
- Reset mid-transaction: the block aborts to IDLE with no drain. The system reset also resets the slave.
- States: IDLE, SEND, RESP.
- IDLE:
  - wr_rdy = 1.
  - wr_req in cycle N captures addr, data, wstrb and type, then moves to SEND.
  - For a line request, the captured address has [3:0] forced to 0.
  - wr_rdy is a state decode, so it is 0 from cycle N+1.
- SEND:
  - awvalid and wvalid both rise in cycle N+1 and run concurrently.
  - awvalid holds until the awready handshake, then aw_done = 1.
  - W beats:
    - wdata = data[32·beat +: 32].
    - wstrb = 4'hF for a line, else the captured wstrb.
    - wlast = (beat == awlen).
  - The beat counter advances only on wvalid & wready.
  - The last beat's handshake sets w_done and drops wvalid.
  - Leave SEND when aw_done and w_done are both true. A same-cycle handshake counts as done.
  - Outputs are held stable while valid and not ready.
- RESP:
  - bready = 1.
  - bvalid moves the block to IDLE in the same cycle; bresp is ignored.
  - The block clears aw_done, w_done and the beat counter.
- AW fields:
  - awaddr = captured address.
  - awlen = 8'd3 for a line, else 8'd0.
  - awsize = 3'b010 for line or word, 3'b001 for half, 3'b000 for byte.
  - awburst = 2'b01 (INCR).
  - awlock = 0, awcache = 0, awprot = 0.
  - awid = wid = WR_ID.
- rd_hazard = (state != IDLE) && (rd_chk_addr[31:4] == buf_addr[31:4]). It is combinational and also applies to uncached entries.
- wb_empty = (state == IDLE).
- Minimum line latency with a zero-wait slave:
  - Accept at N.
  - AW plus beat0 at N+1, beat3 with wlast at N+4.
  - bvalid no earlier than N+5.
  - IDLE and wr_rdy at N+6 at the earliest.
- A wr_req arriving while wr_rdy = 0 is a protocol error. The cache must hold the request, and the buffer ignores it.

Decomposition:
- Shared package:
  - WR_TYPE_BYTE, WR_TYPE_HALF, WR_TYPE_WORD and WR_TYPE_LINE codes.
  - AXI_BURST_INCR and AXI_SIZE_1/2/4 constants.
  - State encoding for IDLE, SEND and RESP.
  - These are shared with the cache and the AXI read bridge.
- No sub-module is needed. Beat selection is a 4:1 mux inside the block.

Test Plan:
- Line eviction, zero-wait slave:
  - Stimulus: wr_req, type 3'b100, addr 0x1C00_0124, data words 0x11111111, 0x22222222, 0x33333333, 0x44444444.
  - Response: awaddr 0x1C00_0120, awlen 3, awsize 2, wdata in that order with wstrb F; wlast only on 0x44444444; wr_rdy back 1 cycle after the bvalid handshake.
- Uncached byte store:
  - Stimulus: type 3'b000, addr 0xBFAF_8003, wstrb 4'b1000, data[31:0] 0xAB00_0000.
  - Response: awlen 0, awsize 0, one beat with wlast = 1 and wstrb 4'b1000.
- Backpressure:
  - Stimulus: awready low for 5 cycles and wready toggling every other cycle on a line request.
  - Response: awaddr and wdata stable while stalled, exactly 4 W handshakes, no RESP before the AW handshake.
- Hazard:
  - Stimulus: with a line at 0x0000_1230 buffered, rd_chk_addr = 0x0000_123C, then 0x0000_1240.
  - Response: rd_hazard 1 then 0; rd_hazard drops in the cycle the block returns to IDLE.
- Async reset:
  - Stimulus: aresetn asserted after beat 1 of a line.
  - Response: awvalid, wvalid and bready drop immediately; wr_rdy = 1 and wb_empty = 1; the next request starts at beat 0.
